// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment patterns
// ({a,b,c,d,e,f,g}, 0 = lit) and the counter-width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h0C;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h60;
    localparam logic [6:0] SEG_C = 7'h31;
    localparam logic [6:0] SEG_D = 7'h42;
    localparam logic [6:0] SEG_E = 7'h30;
    localparam logic [6:0] SEG_F = 7'h38;

    // A counter over n states needs clog2(n) bits, but never fewer than one.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_if.sv
// Bus between digit-producing logic (master) and the scan driver (slave),
// carrying digit data, load strobe, blanking and the shared seg/an pins.
interface seg7_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits_in, load, blank_mask,
        input  seg, an, frame_done
    );

    modport slave (
        input  digits_in, load, blank_mask,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit to active-low 7-segment decoder.
// Define SEG7_HEX_DECODE_EN to show A..F for 10..15; otherwise they are blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // NOTE: default assigned before the case so no path leaves seg unassigned (no latch).
    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0:  seg = SEG_0;
            4'd1:  seg = SEG_1;
            4'd2:  seg = SEG_2;
            4'd3:  seg = SEG_3;
            4'd4:  seg = SEG_4;
            4'd5:  seg = SEG_5;
            4'd6:  seg = SEG_6;
            4'd7:  seg = SEG_7;
            4'd8:  seg = SEG_8;
            4'd9:  seg = SEG_9;
`ifdef SEG7_HEX_DECODE_EN
            4'd10: seg = SEG_A;
            4'd11: seg = SEG_B;
            4'd12: seg = SEG_C;
            4'd13: seg = SEG_D;
            4'd14: seg = SEG_E;
            4'd15: seg = SEG_F;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a refresh
// prescaler, frame-synchronous double buffering and one dead cycle per digit change.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input logic   clk,
    input logic   rst_n,
    seg7_if.slave bus
);

    localparam int IW = width_of(NUM_DIGITS);
    localparam int PW = width_of(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic       tick;
    logic       frame_end;
    logic [3:0] digit;
    logic       digit_blank;
    logic [6:0] digit_seg;

    assign tick      = (pre_q == PRE_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);

    always_comb begin
        digit       = 4'h0;
        digit_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                digit       = display_q[4*k +: 4];
                digit_blank = bus.blank_mask[k];
            end
        end
    end

    seg7_decode u_decode (
        .value (digit),
        .seg   (digit_seg)
    );

    always_comb begin
        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        pending_d = bus.load ? bus.digits_in : pending_q;
        display_d = display_q;
        seg_d     = digit_blank ? SEG_BLANK : digit_seg;
        an_d      = ~(NUM_DIGITS'(1) << idx_q);
        fd_d      = 1'b0;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            // Dead cycle while the anode moves, so the old pattern never ghosts onto the new digit.
            seg_d = SEG_BLANK;
            an_d  = '1;
            fd_d  = frame_end;
        end

        // A load coinciding with the boundary goes straight to the display.
        if (frame_end) begin
            display_d = bus.load ? bus.digits_in : pending_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the digit buffers are reset too, so a load in flight before reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            display_q <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
            fd_q      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            display_q <= display_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit (div 4) and a 1-digit (div 5) instance
// checked every cycle against a cycle-count model, plus literal expectations.
module tb_seg7_scan_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg7_if #(.NUM_DIGITS(4)) bus4 ();
    seg7_if #(.NUM_DIGITS(1)) bus1 ();

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(5)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    typedef struct {
        int          k;
        logic [31:0] pending;
        logic [31:0] display;
    } model_t;

    int tests  = 0;
    int fails  = 0;
    int edge_k = 0;

    model_t     m4, m1;
    logic [6:0] e4_seg = 7'h7F, e1_seg = 7'h7F;
    logic [7:0] e4_an  = 8'hFF, e1_an  = 8'hFF;
    logic       e4_fd  = 1'b0,  e1_fd  = 1'b0;

`ifdef SEG7_HEX_DECODE_EN
    localparam logic [6:0] EXP_A = 7'h08;
    localparam logic [6:0] EXP_F = 7'h38;
`else
    localparam logic [6:0] EXP_A = 7'h7F;
    localparam logic [6:0] EXP_F = 7'h7F;
`endif

    function automatic logic [6:0] ref_decode(input logic [3:0] v);
        case (v)
            4'd0: return 7'h01;   4'd1: return 7'h4F;
            4'd2: return 7'h12;   4'd3: return 7'h06;
            4'd4: return 7'h4C;   4'd5: return 7'h24;
            4'd6: return 7'h20;   4'd7: return 7'h0F;
            4'd8: return 7'h00;   4'd9: return 7'h0C;
`ifdef SEG7_HEX_DECODE_EN
            4'd10: return 7'h08;  4'd11: return 7'h60;
            4'd12: return 7'h31;  4'd13: return 7'h42;
            4'd14: return 7'h30;  4'd15: return 7'h38;
`endif
            default: return 7'h7F;
        endcase
    endfunction

    // Edge k after reset release: slot (k-1)/div selects the digit, the last
    // cycle of each slot is dark, and the last slot of a frame swaps buffers.
    task automatic model_step(input int n, input int div, inout model_t m,
                              input logic [31:0] din, input logic ld,
                              input logic [7:0] blank, output logic [6:0] es,
                              output logic [7:0] ea, output logic efd);
        int p, slot;
        m.k  = m.k + 1;
        p    = (m.k - 1) % div;
        slot = ((m.k - 1) / div) % n;
        ea   = 8'hFF;
        if (p == div - 1) begin
            es  = 7'h7F;
            efd = (slot == n - 1);
            if (slot == n - 1) m.display = ld ? din : m.pending;
        end else begin
            es       = blank[slot] ? 7'h7F : ref_decode(m.display[4*slot +: 4]);
            ea[slot] = 1'b0;
            efd      = 1'b0;
        end
        if (ld) m.pending = din;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_k);
        end
    endtask

    task automatic wait_edge(input int k);
        while (edge_k < k) @(negedge clk);
    endtask

    task automatic check4(input string name, input logic [6:0] s, input logic [3:0] a);
        check({name, "_seg"}, bus4.seg, s);
        check({name, "_an"}, bus4.an, a);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                edge_k = 0;
                m4     = '{0, 32'h0, 32'h0};
                m1     = '{0, 32'h0, 32'h0};
                e4_seg = 7'h7F; e4_an = 8'hFF; e4_fd = 1'b0;
                e1_seg = 7'h7F; e1_an = 8'hFF; e1_fd = 1'b0;
            end else begin
                edge_k = edge_k + 1;
                model_step(4, 4, m4, {16'h0, bus4.digits_in}, bus4.load,
                           {4'h0, bus4.blank_mask}, e4_seg, e4_an, e4_fd);
                model_step(1, 5, m1, {28'h0, bus1.digits_in}, bus1.load,
                           {7'h0, bus1.blank_mask}, e1_seg, e1_an, e1_fd);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && edge_k >= 1) begin
                check("model4_seg", bus4.seg, e4_seg);
                check("model4_an",  bus4.an,  e4_an & 8'h0F);
                check("model4_fd",  bus4.frame_done, e4_fd);
                check("model1_seg", bus1.seg, e1_seg);
                check("model1_an",  bus1.an,  e1_an & 8'h01);
                check("model1_fd",  bus1.frame_done, e1_fd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Single-digit instance: 4 lit cycles, 1 dead cycle, every tick a frame boundary.
    initial begin
        bus1.digits_in  = 4'h0;
        bus1.load       = 1'b0;
        bus1.blank_mask = 1'b0;
        #2;
        wait_edge(1);
        check("d1_first_an", bus1.an, 1'b0);
        check("d1_first_seg", bus1.seg, 7'h01);
        wait_edge(2);
        bus1.digits_in = 4'h7; bus1.load = 1'b1;
        wait_edge(3);
        bus1.load = 1'b0;
        wait_edge(4);
        check("d1_held_seg", bus1.seg, 7'h01);
        wait_edge(5);
        check("d1_dead_an", bus1.an, 1'b1);
        check("d1_dead_fd", bus1.frame_done, 1'b1);
        wait_edge(6);
        check("d1_new_seg", bus1.seg, 7'h0F);
        check("d1_new_an", bus1.an, 1'b0);
        wait_edge(10);
        check("d1_fd2", bus1.frame_done, 1'b1);
        wait_edge(12);
        bus1.blank_mask = 1'b1;
        wait_edge(13);
        check("d1_blank_seg", bus1.seg, 7'h7F);
        check("d1_blank_an", bus1.an, 1'b0);
        wait_edge(14);
        bus1.blank_mask = 1'b0;
    end

    initial begin
        bus4.digits_in  = 16'h0;
        bus4.load       = 1'b0;
        bus4.blank_mask = 4'h0;
        #1 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        wait_edge(1);   check4("reset_release", 7'h01, 4'b1110);
        wait_edge(5);   bus4.digits_in = 16'h1234; bus4.load = 1'b1;
        wait_edge(6);   bus4.load = 1'b0;
        wait_edge(9);   check4("midframe_unchanged", 7'h01, 4'b1011);
        wait_edge(16);  check("frame_done_pulse", bus4.frame_done, 1'b1);
                        check("dead_an", bus4.an, 4'hF);
        wait_edge(17);  check4("load_digit0", 7'h4C, 4'b1110);
        wait_edge(19);  bus4.digits_in = 16'h5555; bus4.load = 1'b1;
        wait_edge(20);  bus4.load = 1'b0;
        wait_edge(29);  check4("load_digit3", 7'h4F, 4'b0111);
        wait_edge(31);  bus4.digits_in = 16'h9999; bus4.load = 1'b1;
        wait_edge(32);  bus4.load = 1'b0;
        wait_edge(33);  check4("bypass_digit0", 7'h0C, 4'b1110);
        wait_edge(39);  bus4.digits_in = 16'hFA00; bus4.load = 1'b1;
        wait_edge(40);  bus4.load = 1'b0;
        wait_edge(45);  check4("bypass_digit3", 7'h0C, 4'b0111);
        wait_edge(49);  check4("hex_digit0", 7'h01, 4'b1110);
        wait_edge(57);  check4("hex_digit2", EXP_A, 4'b1011);
        wait_edge(61);  check4("hex_digit3", EXP_F, 4'b0111);
        wait_edge(64);  bus4.blank_mask = 4'b0101;
        wait_edge(65);  check4("blank_digit0", 7'h7F, 4'b1110);
        wait_edge(66);  bus4.digits_in = 16'h1234; bus4.load = 1'b1;
        wait_edge(67);  bus4.load = 1'b0;
        wait_edge(69);  check4("unblank_digit1", 7'h01, 4'b1101);
        wait_edge(73);  check4("blank_digit2", 7'h7F, 4'b1011);
        wait_edge(85);  check4("mask_digit1", 7'h06, 4'b1101);
        wait_edge(93);  check4("mask_digit3", 7'h4F, 4'b0111);
        wait_edge(96);  bus4.blank_mask = 4'h0;
        wait_edge(101); bus4.digits_in = 16'h5678; bus4.load = 1'b1;
        wait_edge(102); bus4.load = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check4("async_reset", 7'h7F, 4'hF);
        check("async_reset_fd", bus4.frame_done, 1'b0);
        check("async_reset_d1_an", bus1.an, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_edge(1);   check4("rerelease_digit0", 7'h01, 4'b1110);
        wait_edge(17);  check4("pending_discarded", 7'h01, 4'b1110);
        wait_edge(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
